// File: rtl/state_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer and the control-signal generator.
// State IDs are the numeric StateID values both ends decode.
package state_sequencer_pkg;

   localparam int STATE_W_DEF = 6;
   localparam int NREGS_DEF   = 8;

   typedef enum logic [STATE_W_DEF-1:0] {
      S_FETCH    = 6'd0,
      S_ADD_EX   = 6'd1,
      S_ADD_WB   = 6'd2,
      S_ADI_EX   = 6'd3,
      S_ADI_WB   = 6'd4,
      S_SKIP     = 6'd7,
      S_NDU_EX   = 6'd8,
      S_NDU_WB   = 6'd9,
      S_LHI_EX   = 6'd11,
      S_LHI_WB   = 6'd12,
      S_MEM_ADDR = 6'd15,
      S_SW_WRITE = 6'd16,
      S_LW_READ  = 6'd18,
      S_LW_WB    = 6'd19,
      S_JAL_EX   = 6'd20,
      S_JAL_WB   = 6'd21,
      S_BEQ_CMP  = 6'd22,
      S_BEQ_ADD  = 6'd24,
      S_BEQ_PC   = 6'd25,
      S_JLR_EX   = 6'd26,
      S_JLR_WB   = 6'd27,
      S_LM_SCAN  = 6'd30,
      S_LM_READ  = 6'd31,
      S_LM_WB    = 6'd32,
      S_LM_NEXT  = 6'd33,
      S_SM_SCAN  = 6'd34,
      S_SM_WRITE = 6'd35,
      S_SM_ADV   = 6'd36,
      S_SM_NEXT  = 6'd37,
      S_DECODE   = 6'd38
   } state_e;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_LM  = 4'b0110;
   localparam logic [3:0] OP_SM  = 4'b0111;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_C      = 2'b10;

endpackage

// File: rtl/state_sequencer_instr_decode.sv
// Combinational opcode/condition decode: picks the first post-DECODE state.
// Conditional ALU ops whose flag is clear go to SKIP so nothing is written back.
module state_sequencer_instr_decode
   import state_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [1:0] cond,
   input  logic       carry,
   input  logic       zero,
   output state_e     target,
   output logic       illegal
);

   logic cond_valid;
   logic cond_pass;

   always_comb begin
      cond_valid = 1'b1;
      cond_pass  = 1'b0;
      case (cond)
         COND_ALWAYS: cond_pass = 1'b1;
         COND_C:      cond_pass = carry;
         COND_Z:      cond_pass = zero;
         default:     cond_valid = 1'b0;
      endcase
   end

   always_comb begin
      target  = S_FETCH;
      illegal = 1'b0;
      case (opcode)
         OP_ADD, OP_NDU: begin
            if (!cond_valid) begin
               illegal = 1'b1;
            end else if (!cond_pass) begin
               target = S_SKIP;
            end else begin
               target = (opcode == OP_ADD) ? S_ADD_EX : S_NDU_EX;
            end
         end
         OP_ADI:        target = S_ADI_EX;
         OP_LHI:        target = S_LHI_EX;
         OP_LW, OP_SW:  target = S_MEM_ADDR;
         OP_LM:         target = S_LM_SCAN;
         OP_SM:         target = S_SM_SCAN;
         OP_BEQ:        target = S_BEQ_CMP;
         OP_JAL:        target = S_JAL_EX;
         OP_JLR:        target = S_JLR_EX;
         default:       illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/state_sequencer.sv
// Next-state engine for the multicycle datapath; owns the LM/SM register-index counter.
// mem_ready is a one-sided completion strobe: a wait state holds until it is seen high on a posedge.
module state_sequencer
   import state_sequencer_pkg::*;
#(
   parameter int STATE_W = STATE_W_DEF,
   parameter int NREGS   = NREGS_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              IR,
   input  logic                     carry,
   input  logic                     zero,
   input  logic                     compare,
   input  logic                     mem_ready,
   output logic [STATE_W-1:0]       StateID,
   output logic [$clog2(NREGS)-1:0] reg_idx,
   output logic                     instr_done,
   output logic                     illegal_op
);

   localparam int IDX_W = $clog2(NREGS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);

   state_e state;
   state_e state_next;
   state_e dec_target;
   logic   dec_illegal;
   logic   illegal_set;
   logic   idx_clear;
   logic   idx_inc;
   logic   idx_last;
   logic   mask_bit;
   logic   unused_ir;

   assign unused_ir = ^IR[11:8];
   assign idx_last  = (reg_idx == IDX_LAST);
   assign mask_bit  = IR[reg_idx];
   assign StateID   = STATE_W'(state);

   state_sequencer_instr_decode u_decode (
      .opcode  (IR[15:12]),
      .cond    (IR[1:0]),
      .carry   (carry),
      .zero    (zero),
      .target  (dec_target),
      .illegal (dec_illegal)
   );

   always_comb begin
      state_next  = state;
      illegal_set = 1'b0;
      idx_clear   = 1'b0;
      idx_inc     = 1'b0;
      case (state)
         S_FETCH:    if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            idx_clear   = 1'b1;
            state_next  = dec_target;
            illegal_set = dec_illegal;
         end
         S_ADD_EX:   state_next = S_ADD_WB;
         S_ADI_EX:   state_next = S_ADI_WB;
         S_NDU_EX:   state_next = S_NDU_WB;
         S_LHI_EX:   state_next = S_LHI_WB;
         S_JAL_EX:   state_next = S_JAL_WB;
         S_JLR_EX:   state_next = S_JLR_WB;
         S_ADD_WB, S_ADI_WB, S_NDU_WB, S_LHI_WB,
         S_JAL_WB, S_JLR_WB, S_SKIP, S_LW_WB, S_BEQ_PC:
                     state_next = S_FETCH;
         S_MEM_ADDR: state_next = (IR[15:12] == OP_SW) ? S_SW_WRITE : S_LW_READ;
         S_LW_READ:  if (mem_ready) state_next = S_LW_WB;
         S_SW_WRITE: if (mem_ready) state_next = S_FETCH;
         S_BEQ_CMP:  state_next = compare ? S_BEQ_ADD : S_FETCH;
         S_BEQ_ADD:  state_next = S_BEQ_PC;
         S_LM_SCAN:  state_next = mask_bit ? S_LM_READ : S_LM_NEXT;
         S_LM_READ:  if (mem_ready) state_next = S_LM_WB;
         S_LM_WB:    state_next = S_LM_NEXT;
         S_SM_SCAN:  state_next = mask_bit ? S_SM_WRITE : S_SM_NEXT;
         S_SM_WRITE: if (mem_ready) state_next = S_SM_ADV;
         S_SM_ADV:   state_next = S_SM_NEXT;
         S_LM_NEXT, S_SM_NEXT: begin
            if (idx_last) begin
               state_next = S_FETCH;
            end else begin
               idx_inc    = 1'b1;
               state_next = (state == S_LM_NEXT) ? S_LM_SCAN : S_SM_SCAN;
            end
         end
         // Unused encodings recover to FETCH and flag the event.
         default: begin
            state_next  = S_FETCH;
            illegal_set = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         reg_idx    <= '0;
         instr_done <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state      <= state_next;
         instr_done <= (state != S_FETCH) && (state_next == S_FETCH);
         illegal_op <= illegal_op | illegal_set;
         if (idx_clear) begin
            reg_idx <= '0;
         end else if (idx_inc) begin
            reg_idx <= reg_idx + 1'b1;
         end
      end
   end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Next-state engine for the multicycle RISC datapath. It produces the StateID consumed by the control-signal generator, which drives the mux selects and write enables.
- Decodes the latched IR and walks each instruction through fetch, decode, execute, memory and writeback states.
- Steps ALU and flag conditions, the BEQ compare result and memory-ready handshakes; loops over the LM/SM register list.
- Owns the LM/SM register-index counter.

Parameters:
- STATE_W, 6, width of StateID.
- NREGS, 8, register count; also LM/SM mask width and loop bound.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- IR  in  16  latched instruction; valid from DECODE onward. Opcode is IR[15:12], condition is IR[1:0], LM/SM mask is IR[7:0].
- carry  in  1  registered carry flag.
- zero  in  1  registered zero flag.
- compare  in  1  BEQ equality result; sampled in state 22 only.
- mem_ready  in  1  memory access completes this cycle.
- StateID  out  6  current state, registered.
- reg_idx  out  3  LM/SM register index, registered.
- instr_done  out  1  one-cycle pulse, registered.
- illegal_op  out  1  sticky flag, registered.

Behaviour:
- Reset (asynchronous, any cycle including mid-LM/SM or mid-memory wait):
  - StateID=0, reg_idx=0, instr_done=0, illegal_op=0.
  - The abandoned access is not resumed.
- Outputs are registered; StateID changes only on posedge clk.
- Fetch and decode:
  - 0 FETCH: stays while mem_ready=0, then goes to 38 DECODE.
  - 38 DECODE: reg_idx<=0, then branches on opcode.
  - 0000 ADD/ADC/ADZ: IR[1:0]=00 goes to 1. 10 goes to 1 if carry, else 7. 01 goes to 1 if zero, else 7. 11 is illegal.
  - 0010 NDU/NDC/NDZ: same condition rule, going to 8 or 7.
  - 0001 ADI goes to 3. 0011 LHI goes to 11. 0100 LW and 0101 SW go to 15. 0110 LM goes to 30. 0111 SM goes to 34. 1100 BEQ goes to 22. 1000 JAL goes to 20. 1001 JLR goes to 26.
  - Any other opcode or condition: set illegal_op and go to 0 (executes as a NOP).
- ALU and jump chains: 1→2→0, 3→4→0, 8→9→0, 11→12→0, 20→21→0, 26→27→0, 7 SKIP→0.
- Memory:
  - LW: 15→18 READ; stays in 18 while mem_ready=0, then →19 WB→0.
  - SW: 15→16 WRITE; stays in 16 while mem_ready=0, then →0.
- BEQ: in 22, compare=1 goes to 24→25→0; compare=0 goes to 0.
- LM loop:
  - 30 SCAN: IR[reg_idx]=1 goes to 31; otherwise to 33.
  - 31 READ: waits on mem_ready, then →32 WB→33.
  - 33 NEXT: reg_idx==NREGS-1 goes to 0; otherwise reg_idx<=reg_idx+1 and back to 30.
- SM loop: same shape with 34 SCAN, 35 WRITE (waits on mem_ready), 36 ADV, 37 NEXT.
- reg_idx advances only in 33 and 37; it never wraps past 7 inside a loop. An empty mask visits all 8 indices with no access.
- instr_done goes high for the first cycle of FETCH entered from any non-zero state. It is not asserted after reset or while FETCH waits.
- Unused codes (5, 6, 10, 13, 14, 17, 23, 28, 29, 39-63): if ever reached, go to 0 and set illegal_op.
- mem_ready has no effect outside states 0, 18, 16, 31 and 35.
- Latencies with mem_ready=1 in the first cycle: ADD 4 cycles, LW 5, SW 4, BEQ taken 5 / not-taken 3. LM with k set bits takes 2+8*2+k*2 cycles.

Decomposition:
- Shared package holds: state-ID localparams (S_FETCH=0 … S_DECODE=38), opcode constants, and condition codes COND_ALWAYS, COND_C, COND_Z.
- The controller imports the same package so both ends agree on encodings.
- Optional combinational sub-module instr_decode (IR, carry, zero → target state, illegal). The loop counter and FSM stay in state_sequencer.

Test Plan:
- ADD, IR=16'h0000, mem_ready=1 → StateID 0,38,1,2,0; instr_done pulses once on the return to 0.
- ADC, IR[1:0]=10, carry=0 → 0,38,7,0. Repeat with carry=1 → 0,38,1,2,0.
- LW with mem_ready held low 3 cycles in state 18 → StateID stays 18 for 3 cycles, then 19, then 0.
- LM with IR[7:0]=8'b1000_0101 → reg_idx steps 0..7. States 31/32 are visited only at idx 0, 2 and 7; ends at 0 after 24 cycles.
- BEQ with compare=1 → 22,24,25,0. BEQ with compare=0 → 22,0.
- Opcode 4'b1111 → illegal_op=1 and StateID back to 0. rst pulsed while in state 35 → StateID=0, reg_idx=0 and illegal_op=0 immediately, without waiting for a clock edge.
